bcd_seg_scan: RTL

Display stage directly downstream of the 9-bit binary-to-BCD converter. It consumes the 12-bit, 3-digit BCD word and time-multiplexes it onto a common-anode 3-digit 7-segment display. Features:
- Tear-free frame-boundary update.
- Optional leading-zero blanking.
- Inter-digit ghost blanking.
- Invalid-nibble indication.

---
 rtl/bcd_seg_scan.sv | 71 +++++++
 1 files changed

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexes a 3-digit BCD word onto a common-anode 7-segment display, updating only at frame boundaries
module bcd_seg_scan #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] bcd,
   input  logic        load,
   input  logic        blank_lz,
   output logic [2:0]  an,
   output logic [6:0]  seg,
   output logic        frame_done
);
   localparam int CW = $clog2(SCAN_DIV);
   typedef enum logic [1:0] {D0, D1, D2} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [11:0] shadow, disp;
   logic pending, tick, bnd, blanked, off;
   logic [3:0] nib;
   logic [2:0] an_sel;
   logic [6:0] dec;
   assign tick = cnt == CW'(SCAN_DIV - 1);
   assign bnd = tick && state == D2;
   always_comb state_n = !tick ? state : state == D0 ? D1 : state == D1 ? D2 : D0;
   assign nib = state == D0 ? disp[3:0] : state == D1 ? disp[7:4] : disp[11:8];
   assign an_sel = state == D0 ? 3'b110 : state == D1 ? 3'b101 : 3'b011;
   // a blanked leading zero also keeps its anode off, so the slot stays dark
   assign blanked = blank_lz && disp[11:8] == 4'd0 && (state == D2 || (state == D1 && disp[7:4] == 4'd0));
   assign off = cnt < CW'(BLANK_CYC) || blanked;
   always_comb begin
      dec = 7'h3F;
      case (nib)
         4'd0: dec = 7'h40;
         4'd1: dec = 7'h79;
         4'd2: dec = 7'h24;
         4'd3: dec = 7'h30;
         4'd4: dec = 7'h19;
         4'd5: dec = 7'h12;
         4'd6: dec = 7'h02;
         4'd7: dec = 7'h78;
         4'd8: dec = 7'h00;
         4'd9: dec = 7'h10;
         default: dec = 7'h3F;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         state      <= D0;
         shadow     <= '0;
         disp       <= '0;
         pending    <= 1'b0;
         an         <= 3'b111;
         seg        <= 7'h7F;
         frame_done <= 1'b0;
      end else begin
         cnt        <= tick ? '0 : cnt + 1'b1;
         state      <= state_n;
         an         <= off ? 3'b111 : an_sel;
         seg        <= off ? 7'h7F : dec;
         frame_done <= bnd;
         if (load) shadow <= bcd;
         if (bnd) begin
            disp    <= load ? bcd : pending ? shadow : disp;
            pending <= 1'b0;
         end else if (load) pending <= 1'b1;
      end
   end
endmodule
